// File: rtl/neopixel_frame_ctrl_if.sv
// neopixel_frame_ctrl_if
//   Bundles the UART byte stream, the writepixel handshake and the frame status
//   lines of neopixel_frame_ctrl.
//   master : the frame controller (consumes rx_*, px_busy; drives px_*, status).
//   slave  : the surrounding logic (rxuart, writepixel, status consumers).
//   Signals: rx_byte[7:0], rx_valid, px_valid, px_r/px_g/px_b[7:0], px_busy,
//            frame_active, frame_done, rx_err.
interface neopixel_frame_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       px_valid;
    logic [7:0] px_r;
    logic [7:0] px_g;
    logic [7:0] px_b;
    logic       px_busy;
    logic       frame_active;
    logic       frame_done;
    logic       rx_err;

    modport master (
        input  rx_byte, rx_valid, px_busy,
        output px_valid, px_r, px_g, px_b, frame_active, frame_done, rx_err
    );

    modport slave (
        output rx_byte, rx_valid, px_busy,
        input  px_valid, px_r, px_g, px_b, frame_active, frame_done, rx_err
    );
endinterface

// File: rtl/neopixel_frame_ctrl.sv
// neopixel_frame_ctrl
//   Pixel store plus frame scheduler for a NeoPixel chain. A 4-byte packet parser
//   (index, R, G, B) fills the store from the UART byte stream; every refresh
//   period the sequencer walks the store in index order through writepixel using
//   its valid/busy handshake, then holds a latch gap before returning to idle.
// Ports:
//   CLK : clock, rising edge only
//   RST : synchronous active-high reset (aborts any frame, clears the store)
//   np  : neopixel_frame_ctrl_if.master (rx stream in, pixel handshake, status)
// Build option:
//   NEOPIXEL_SHADOW_BUF_EN : parser writes a shadow store which is copied into the
//   display store when a frame starts, giving tear-free frames.
module neopixel_frame_ctrl #(
    parameter int unsigned NUM_PIXELS     = 10,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned GAP_CYCLES     = 1200,
    parameter int unsigned REFRESH_CYCLES = 1048576,
    parameter int unsigned RX_TIMEOUT     = 120000
) (
    input logic                    CLK,
    input logic                    RST,
    neopixel_frame_ctrl_if.master  np
);
    localparam int unsigned RefW = $clog2(REFRESH_CYCLES);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(RX_TIMEOUT + 1);

    localparam logic [RefW-1:0]  RefLast = RefW'(REFRESH_CYCLES - 1);
    localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(RX_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_PIXELS - 1);

    // ---------------------------------------------------------------- parser
    typedef enum logic [1:0] {PIdx, PR, PG, PB} p_state_e;

    p_state_e         p_state_q, p_state_d;
    logic [IDX_W-1:0] p_idx_q;
    logic [7:0]       p_r_q;
    logic [7:0]       p_g_q;
    logic [TmoW-1:0]  tmo_cnt_q;
    logic             rx_err_q, rx_err_d;
    logic             idx_ok, tmo_hit, st_we;

    assign idx_ok  = 32'(np.rx_byte) < NUM_PIXELS;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = (p_state_q != PIdx) && !np.rx_valid && (tmo_cnt_q == TmoLast);

    always_comb begin
        p_state_d = p_state_q;
        case (p_state_q)
            PIdx: if (np.rx_valid && idx_ok) p_state_d = PR;
            PR: begin
                if (np.rx_valid)  p_state_d = PG;
                else if (tmo_hit) p_state_d = PIdx;
            end
            PG: begin
                if (np.rx_valid)  p_state_d = PB;
                else if (tmo_hit) p_state_d = PIdx;
            end
            PB: begin
                if (np.rx_valid)  p_state_d = PIdx;
                else if (tmo_hit) p_state_d = PIdx;
            end
            default: p_state_d = PIdx;
        endcase
    end

    always_comb begin
        st_we    = (p_state_q == PB) && np.rx_valid;
        rx_err_d = tmo_hit || ((p_state_q == PIdx) && np.rx_valid && !idx_ok);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_state_q <= PIdx;
            p_idx_q   <= '0;
            p_r_q     <= '0;
            p_g_q     <= '0;
            tmo_cnt_q <= '0;
            rx_err_q  <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            rx_err_q  <= rx_err_d;
            if (np.rx_valid || (p_state_d == PIdx)) tmo_cnt_q <= '0;
            else                                    tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            if (np.rx_valid) begin
                case (p_state_q)
                    PIdx:    if (idx_ok) p_idx_q <= np.rx_byte[IDX_W-1:0];
                    PR:      p_r_q <= np.rx_byte;
                    PG:      p_g_q <= np.rx_byte;
                    default: ;
                endcase
            end
        end
    end

    // ----------------------------------------------------------- pixel store
    logic [23:0] disp_q [NUM_PIXELS];
    logic        frame_start;

`ifdef NEOPIXEL_SHADOW_BUF_EN
    logic [23:0] shadow_q [NUM_PIXELS];

    // The copy reads the pre-edge shadow, so a write on the start edge waits a frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_PIXELS); i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            if (st_we) shadow_q[p_idx_q] <= {p_r_q, p_g_q, np.rx_byte};
            if (frame_start) begin
                for (int i = 0; i < int'(NUM_PIXELS); i++) disp_q[i] <= shadow_q[i];
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_PIXELS); i++) disp_q[i] <= '0;
        end else if (st_we) begin
            disp_q[p_idx_q] <= {p_r_q, p_g_q, np.rx_byte};
        end
    end
`endif

    // ------------------------------------------------------- frame sequencer
    typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StGap} seq_state_e;

    seq_state_e       state_q, state_d;
    logic [RefW-1:0]  ref_cnt_q, ref_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
    logic             px_valid_q;
    logic [23:0]      px_rgb_q;
    logic             frame_active_q, frame_active_d;
    logic             issue, done_pulse;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            ref_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            pix_idx_q      <= '0;
            px_valid_q     <= 1'b0;
            px_rgb_q       <= '0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ref_cnt_q      <= ref_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pix_idx_q      <= pix_idx_d;
            px_valid_q     <= issue;
            frame_active_q <= frame_active_d;
            // Read-before-write: a same-cycle store write is not seen here.
            if (issue) px_rgb_q <= disp_q[pix_idx_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pix_idx_d = pix_idx_q;
        case (state_q)
            StIdle: begin
                if (ref_cnt_q == RefLast) begin
                    ref_cnt_d = '0;
                    pix_idx_d = '0;
                    state_d   = StIssue;
                end else begin
                    ref_cnt_d = ref_cnt_q + RefW'(1);
                end
            end
            StIssue:  if (!np.px_busy) state_d = StWaitHi;
            StWaitHi: if (np.px_busy)  state_d = StWaitLo;
            StWaitLo: begin
                if (!np.px_busy) begin
                    if (pix_idx_q == IdxLast) begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                        state_d   = StIssue;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_start    = (state_q == StIdle) && (ref_cnt_q == RefLast);
        issue          = (state_q == StIssue) && !np.px_busy;
        done_pulse     = (state_q == StGap) && (gap_cnt_q == GapLast);
        frame_active_d = frame_active_q;
        if (frame_start)     frame_active_d = 1'b1;
        else if (done_pulse) frame_active_d = 1'b0;
    end

    assign np.px_valid     = px_valid_q;
    assign np.px_r         = px_rgb_q[23:16];
    assign np.px_g         = px_rgb_q[15:8];
    assign np.px_b         = px_rgb_q[7:0];
    assign np.frame_active = frame_active_q;
    assign np.frame_done   = done_pulse;
    assign np.rx_err       = rx_err_q;
endmodule

// File: doc/neopixel_frame_ctrl.md
# neopixel_frame_ctrl

Frame scheduler and pixel store for the PMOD NeoPixel chain. Holds an RGB value per pixel, fills it from the UART receiver's byte stream, and on a fixed refresh period walks the store through the single-pixel `writepixel` serializer using its valid/busy handshake. After the last pixel it inserts the latch gap the LEDs need. It replaces the free-running counter and index glue that currently sit in `top`.

## Interface
- `NUM_PIXELS`, default 10: pixels in the chain; range 1..16.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ NUM_PIXELS.
- `GAP_CYCLES`, default 1200: idle cycles after the last pixel (latch time); must be ≥ 1.
- `REFRESH_CYCLES`, default 1048576: idle cycles between frames; must be ≥ 2.
- `RX_TIMEOUT`, default 120000: inter-byte silence, in cycles, that aborts a partial packet.

Ports:
- `CLK` input, 1 bit: the only clock; all logic is on the rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `rx_byte` input, 8 bits: received byte from `rxuart`.
- `rx_valid` input, 1 bit: one-cycle strobe; `rx_byte` is valid in that cycle.
- `px_valid` output, 1 bit: one-cycle start strobe to `writepixel`.
- `px_r`, `px_g`, `px_b` outputs, 8 bits each: colour of the pixel being sent.
- `px_busy` input, 1 bit: `writepixel` is shifting.
- `frame_active` output, 1 bit: high from the first issue until the gap ends.
- `frame_done` output, 1 bit: one-cycle pulse when the gap ends.
- `rx_err` output, 1 bit: one-cycle pulse on a bad index byte or a packet timeout.

## Operation
**Pixel store**
- `NUM_PIXELS` entries of 24 bits: {R, G, B}.
- Reset clears every entry to 0.

**Packet parser**
- States: P_IDX → P_R → P_G → P_B.
- P_IDX: a byte below `NUM_PIXELS` is latched as the index and the parser moves to P_R. A byte at or above `NUM_PIXELS` is dropped, `rx_err` pulses, and the parser stays in P_IDX.
- P_R and P_G: latch the byte and advance.
- P_B: writes {R, G, rx_byte} to the entry at the latched index on that clock edge, then returns to P_IDX.
- Timeout: outside P_IDX, `RX_TIMEOUT` consecutive cycles without `rx_valid` send the parser to P_IDX, pulse `rx_err`, and discard the partial packet.

**Frame sequencer**
- IDLE: the refresh counter increments each cycle. When it reaches `REFRESH_CYCLES`−1, it clears, the pixel index is set to 0, `frame_active` is set, and the state becomes ISSUE.
- ISSUE: if `px_busy`=1, hold with `px_valid` low. Otherwise drive `px_valid`=1 for exactly one cycle, load `px_r/g/b` from the pixel at the current index, and go to WAIT_HI.
- WAIT_HI: hold until `px_busy`=1, then go to WAIT_LO.
- WAIT_LO: hold until `px_busy`=0. Then, if the index equals `NUM_PIXELS`−1, go to GAP; otherwise increment the index and go to ISSUE.
- GAP: count `GAP_CYCLES` cycles. On the last one, pulse `frame_done`, clear `frame_active`, and return to IDLE.
- Pixels are always sent in index order 0..N−1. `writepixel` applies the wire colour order.

## Timing
**Reset values**
- Registers: state IDLE, parser P_IDX, all counters and the pixel index 0.
- Outputs: `px_valid`, `px_r/g/b`, `frame_active`, `frame_done` and `rx_err` are all 0.
- A reset in any state, including mid-frame, aborts the frame with no further `px_valid` and zeroes the store.

**Handshake and latency**
- `px_r/g/b` are registered. They change only on the cycle `px_valid` rises and hold until the next issue.
- `px_valid` comes from a register: it is high in the cycle after ISSUE is entered, provided `px_busy` is low.
- `writepixel` raises `px_busy` one cycle after `px_valid`. WAIT_HI tolerates any delay.
- The next `px_valid` comes no earlier than 2 cycles after `px_busy` falls.
- Minimum frame-to-frame distance is `REFRESH_CYCLES` + gap + N × (shift time + 3) cycles.

**Store access**
- Only the parser writes the store; only the sequencer reads it.
- A write and a read of the same entry in the same cycle: the read returns the old value.

**Simultaneous events**
- An `rx_valid` in the same cycle as the timeout expiry counts as a byte, and the timeout does not fire.
- `rx_err` and a store write never occur in the same cycle.

## Configuration
Macro: `NEOPIXEL_SHADOW_BUF_EN`.
- **Defined:** the parser writes a separate shadow store, and the whole shadow is copied into the display store on the IDLE→ISSUE edge. Frames are tear-free. A write landing on that same edge reaches the shadow but is not in the copy; it is shown in the next frame.
- **Undefined:** there is a single store, and a packet completing mid-frame is visible to any pixel not yet issued in the current frame.

## Test plan
Common bench parameters: `NUM_PIXELS`=4, `GAP_CYCLES`=8, `REFRESH_CYCLES`=64, `RX_TIMEOUT`=32. The `writepixel` model raises busy 1 cycle after valid and holds it for 24 cycles.

1. **Refresh and gap:** reset, then no RX → first `px_valid` at cycle 65 after reset release; exactly 4 `px_valid` pulses, all with RGB=0; `frame_done` pulses 8 cycles after the last busy fall; the next frame starts 64 cycles later.
2. **Packet write:** bytes 0x02, 0x11, 0x22, 0x33 → the next frame's third issue carries R=0x11, G=0x22, B=0x33; the other pixels stay 0.
3. **Bad index:** byte 0x07 → `rx_err` pulses one cycle; a following 0x01, 0xAA, 0xBB, 0xCC writes pixel 1 normally.
4. **Timeout:** 0x00, 0x55, then 40 idle cycles → `rx_err` pulse and pixel 0 unchanged; a fresh packet 0x00, 1, 2, 3 writes {1, 2, 3}.
5. **Busy at issue:** force `px_busy`=1 for 10 cycles as ISSUE is entered → `px_valid` held low until busy drops, then a single pulse.
6. **Mid-frame write and reset:** packet to pixel 3 completed during pixel 1's shift → pixel 3 is sent this frame without the macro and next frame with it. Assert `RST` during pixel 2 → outputs zero and no further issues until 64 cycles after release.
